inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-entry-in / dual-entry-out instruction buffer between the IF stage and the decode stage of the dual-issue core.
- Accepts up to two fetched instructions per cycle (each with pc, npc, inst) and presents the two oldest entries to decode.
- Decode retires 0, 1 or 2 entries per cycle.
- Emptied in one cycle on a branch redirect.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
PC_W, 32, width of pc/npc fields
INST_W, 32, width of instruction field

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  branch redirect; discard all entries (synchronous)
in_ready  output  1  queue can accept a full 2-entry fetch packet this cycle
in1_valid  input  1  fetch slot 1 carries an instruction
in1_pc  input  PC_W  slot 1 pc
in1_npc  input  PC_W  slot 1 predicted next pc
in1_inst  input  INST_W  slot 1 instruction
in2_valid  input  1  fetch slot 2 carries an instruction (younger than slot 1)
in2_pc  input  PC_W  slot 2 pc
in2_npc  input  PC_W  slot 2 predicted next pc
in2_inst  input  INST_W  slot 2 instruction
out1_valid  output  1  oldest entry present
out1_pc / out1_npc / out1_inst  output  PC_W/PC_W/INST_W  oldest entry fields
out2_valid  output  1  second-oldest entry present
out2_pc / out2_npc / out2_inst  output  PC_W/PC_W/INST_W  second-oldest entry fields
pop_n  input  2  entries consumed by decode this cycle (0,1,2)

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr, wr_ptr, count cleared to 0. Storage array is not reset.
  - Resulting outputs: out1_valid=0, out2_valid=0, all out data=0, in_ready=1.
- State:
  - rd_ptr, wr_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits, range 0..DEPTH.
- in_ready = (count <= DEPTH-2), from registered count only. Combinational, with no dependence on pop_n (no pop-to-push bypass).
- Push (when in_ready=1 and flush=0):
  - in1_valid=1: slot 1 written at wr_ptr.
  - in1_valid=1 and in2_valid=1: slot 2 also written at wr_ptr+1.
  - in2_valid with in1_valid=0 is ignored (fetch packs oldest first).
  - push_n = in1_valid + (in1_valid & in2_valid); wr_ptr += push_n.
  - in_ready=0: inputs ignored; IF must hold its packet.
- Pop: first-word fall-through.
  - out1 = entry[rd_ptr], valid when count >= 1.
  - out2 = entry[rd_ptr+1], valid when count >= 2.
  - Data outputs are forced to 0 whenever their valid is low.
  - Effective pop = min(pop_n, count); pop_n=3 is treated as 2. rd_ptr += effective pop.
- Simultaneous push and pop are allowed in the same cycle; count_next = count + push_n - pop_eff.
  - Pop reads the pre-edge entries; a push never overwrites an unpopped entry, guaranteed by the in_ready rule.
- Latency: an entry written at edge N is visible on out1/out2 after edge N (1 cycle from in*_valid to out*_valid). No same-cycle bypass.
- Flush=1 has highest priority: at the edge, rd_ptr=wr_ptr=count=0.
  - Same-cycle push and pop are discarded.
  - Next cycle: out valids 0, in_ready=1.
- Wrap-around: pointers wrap silently. A 2-entry push at wr_ptr=DEPTH-1 writes indices DEPTH-1 and 0.
- Ordering: strict FIFO; slot 1 is always older than slot 2 within a packet.
- Reset mid-operation: immediate return to the reset state regardless of pending push/pop.

Test Plan:
- Reset then idle:
  - Response: out1_valid=out2_valid=0, in_ready=1, out data=0.
- Single push of pc=0x80000000/npc=0x80000004/inst=0x00100093 and pc=0x80000004/npc=0x80000008/inst=0x00200113, pop_n=0:
  - Next cycle: both valid, out1_pc=0x80000000, out2_pc=0x80000004, count=2.
- Fill with 2-entry pushes, pop_n=0:
  - in_ready drops to 0 when count=7 or 8 (DEPTH=8).
  - Further pushes are ignored; popping 2 reasserts in_ready once count <= 6.
- Steady state, push 2 and pop 2 every cycle for 20 cycles across pointer wrap:
  - Outputs follow the pc sequence 0x80000000 + 4*k with no gaps or duplicates; count constant.
- pop_n=2 with count=1:
  - Only one entry removed; count=0; out1_valid=0 next cycle, no underflow.
- flush with count=5, simultaneous 2-entry push and pop_n=2:
  - Next cycle count=0, both valids 0.
  - A following push appears at out1 with its own pc; no stale entries.

Source files
------------

// File: rtl/inst_queue.sv
// Purpose : dual-in / dual-out FWFT instruction buffer between fetch and decode.
// Latency : 1 cycle from in*_valid to out*_valid; no same-cycle bypass.
// Backpr. : in_ready low when fewer than 2 free slots; the fetch packet must be held.
//
// Ports:
//   clk, rst (async active-low), flush (sync redirect, highest priority)
//   in_ready, in1_* / in2_* : up to two fetched instructions per cycle, slot 1 oldest
//   out1_* / out2_*         : two oldest entries, data forced to 0 when not valid
//   pop_n                   : entries consumed by decode this cycle (3 behaves as 2)
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              in_ready,
    input  logic              in1_valid,
    input  logic [PC_W-1:0]   in1_pc,
    input  logic [PC_W-1:0]   in1_npc,
    input  logic [INST_W-1:0] in1_inst,
    input  logic              in2_valid,
    input  logic [PC_W-1:0]   in2_pc,
    input  logic [PC_W-1:0]   in2_npc,
    input  logic [INST_W-1:0] in2_inst,
    output logic              out1_valid,
    output logic [PC_W-1:0]   out1_pc,
    output logic [PC_W-1:0]   out1_npc,
    output logic [INST_W-1:0] out1_inst,
    output logic              out2_valid,
    output logic [PC_W-1:0]   out2_pc,
    output logic [PC_W-1:0]   out2_npc,
    output logic [INST_W-1:0] out2_inst,
    input  logic [1:0]        pop_n
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_p1, wr_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] push_n, pop_req, pop_eff;
    logic             push1, push2;
    entry_t           head1, head2;

    always_comb begin
        // Registered count only: a same-cycle pop never frees space for this push.
        in_ready  = (count_q <= CNT_W'(DEPTH - 2));
        push1     = in_ready & ~flush & in1_valid;
        // Slot 2 without slot 1 is not a legal packet and is dropped.
        push2     = push1 & in2_valid;
        push_n    = CNT_W'(push1) + CNT_W'(push2);
        rd_ptr_p1 = rd_ptr_q + AW'(1);
        wr_ptr_p1 = wr_ptr_q + AW'(1);

        case (pop_n)
            2'd0:    pop_req = '0;
            2'd1:    pop_req = CNT_W'(1);
            default: pop_req = CNT_W'(2);
        endcase
        // Never retire more than is present.
        pop_eff = (pop_req > count_q) ? count_q : pop_req;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + pop_eff[AW-1:0];
            wr_ptr_d = wr_ptr_q + push_n[AW-1:0];
            count_d  = count_q + push_n - pop_eff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are only observable through the valid gating below.
    always_ff @(posedge clk) begin
        if (push1) mem_q[wr_ptr_q]  <= '{pc: in1_pc, npc: in1_npc, inst: in1_inst};
        if (push2) mem_q[wr_ptr_p1] <= '{pc: in2_pc, npc: in2_npc, inst: in2_inst};
    end

    always_comb begin
        head1      = mem_q[rd_ptr_q];
        head2      = mem_q[rd_ptr_p1];
        out1_valid = (count_q != '0);
        out2_valid = (count_q >= CNT_W'(2));
        out1_pc    = out1_valid ? head1.pc   : '0;
        out1_npc   = out1_valid ? head1.npc  : '0;
        out1_inst  = out1_valid ? head1.inst : '0;
        out2_pc    = out2_valid ? head2.pc   : '0;
        out2_npc   = out2_valid ? head2.npc  : '0;
        out2_inst  = out2_valid ? head2.inst : '0;
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_ready;
    logic        in1_valid, in2_valid;
    logic [31:0] in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst;
    logic        out1_valid, out2_valid;
    logic [31:0] out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst;
    logic [1:0]  pop_n;

    int checks = 0;
    int errors = 0;
    ent_t        model_q[$];
    logic [31:0] seq_pc = 32'h8000_0000;

    inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_ready(in_ready),
        .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_inst(in1_inst),
        .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_inst(in2_inst),
        .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_inst(out1_inst),
        .out2_valid(out2_valid), .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_inst(out2_inst),
        .pop_n(pop_n)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs the queue contents imply: two oldest entries, zero when absent.
    task automatic check_model();
        ent_t e1, e2;
        bit v1, v2;
        v1 = model_q.size() >= 1;
        v2 = model_q.size() >= 2;
        e1 = v1 ? model_q[0] : '0;
        e2 = v2 ? model_q[1] : '0;
        chk("in_ready",   in_ready,   model_q.size() <= DEPTH - 2);
        chk("out1_valid", out1_valid, v1);
        chk("out1_pc",    out1_pc,    e1.pc);
        chk("out1_npc",   out1_npc,   e1.npc);
        chk("out1_inst",  out1_inst,  e1.inst);
        chk("out2_valid", out2_valid, v2);
        chk("out2_pc",    out2_pc,    e2.pc);
        chk("out2_npc",   out2_npc,   e2.npc);
        chk("out2_inst",  out2_inst,  e2.inst);
    endtask

    task automatic set_in(bit v1, bit v2, logic [1:0] pn, bit fl);
        in1_valid = v1;
        in2_valid = v2;
        in1_pc    = seq_pc;
        in1_npc   = seq_pc + 32'd4;
        in1_inst  = $urandom;
        in2_pc    = seq_pc + 32'd4;
        in2_npc   = seq_pc + 32'd8;
        in2_inst  = $urandom;
        pop_n     = pn;
        flush     = fl;
        if (!fl && model_q.size() <= DEPTH - 2 && v1)
            seq_pc += v2 ? 32'd8 : 32'd4;
    endtask

    // Apply current inputs to the model, clock once, then compare.
    task automatic tick();
        int pe;
        bit rdy;
        rdy = model_q.size() <= DEPTH - 2;
        if (flush) begin
            model_q.delete();
        end else begin
            pe = (pop_n == 2'd3) ? 2 : int'(pop_n);
            if (pe > model_q.size()) pe = model_q.size();
            repeat (pe) void'(model_q.pop_front());
            if (rdy && in1_valid) begin
                model_q.push_back('{pc: in1_pc, npc: in1_npc, inst: in1_inst});
                if (in2_valid)
                    model_q.push_back('{pc: in2_pc, npc: in2_npc, inst: in2_inst});
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 2'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        // Reset state, hand-computed.
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out2_valid", out2_valid, 0);
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out1_pc",    out1_pc,    0);
        check_model();
        rst = 1'b1;

        // First packet with fixed contents.
        set_in(1, 1, 2'd0, 0);
        in1_inst = 32'h0010_0093;
        in2_inst = 32'h0020_0113;
        tick();
        chk("p1_out1_pc",   out1_pc,   32'h8000_0000);
        chk("p1_out1_npc",  out1_npc,  32'h8000_0004);
        chk("p1_out2_pc",   out2_pc,   32'h8000_0004);
        chk("p1_out2_inst", out2_inst, 32'h0020_0113);
        chk("p1_out2_valid", out2_valid, 1);

        // Fill: 2 -> 4 -> 6 -> 8, then pushes are ignored.
        set_in(1, 1, 2'd0, 0); tick();
        set_in(1, 1, 2'd0, 0); tick();
        chk("fill6_ready", in_ready, 1);
        set_in(1, 1, 2'd0, 0); tick();
        chk("fill8_ready", in_ready, 0);
        set_in(1, 1, 2'd0, 0); tick();
        chk("full_hold_pc", out1_pc, 32'h8000_0000);
        set_in(0, 0, 2'd2, 0); tick();
        chk("pop_ready", in_ready, 1);
        chk("pop_head",  out1_pc,  32'h8000_0008);

        // Steady push 2 / pop 2 across pointer wrap.
        for (int k = 0; k < 20; k++) begin
            set_in(1, 1, 2'd2, 0);
            tick();
            chk("steady_ready", in_ready, 1);
            chk("steady_head",  out1_pc, 32'h8000_0010 + 32'(8 * k));
        end

        // Drain, then pop_n=2 with a single entry.
        repeat (4) begin set_in(0, 0, 2'd2, 0); tick(); end
        chk("drained", out1_valid, 0);
        set_in(1, 0, 2'd0, 0); tick();
        chk("one_v1", out1_valid, 1);
        chk("one_v2", out2_valid, 0);
        set_in(0, 0, 2'd2, 0); tick();
        chk("under_v1", out1_valid, 0);
        set_in(0, 0, 2'd3, 0); tick();
        chk("under_ready", in_ready, 1);

        // Flush at count=5 with simultaneous push and pop.
        set_in(1, 1, 2'd0, 0); tick();
        set_in(1, 1, 2'd0, 0); tick();
        set_in(1, 0, 2'd0, 0); tick();
        set_in(1, 1, 2'd2, 1); tick();
        chk("flush_v1",    out1_valid, 0);
        chk("flush_v2",    out2_valid, 0);
        chk("flush_ready", in_ready,   1);
        seq_pc = 32'h9000_0000;
        set_in(1, 0, 2'd0, 0); tick();
        chk("post_flush_pc", out1_pc,    32'h9000_0000);
        chk("post_flush_v2", out2_valid, 0);

        // Asynchronous reset mid-operation.
        set_in(1, 1, 2'd1, 0); tick();
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 49) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
